pmem_arbiter: RTL and testbench

//  Shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write).

---
 rtl/pmem_arb_pkg.sv | 15 +
 rtl/pmem_arb_pick.sv | 29 ++
 rtl/pmem_arbiter.sv | 112 +++++++++++
 tb/tb_pmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// Shared types for the physical-memory arbiter between icache and dcache.
// Build option PMEM_ARB_RR_EN (see pmem_arb_pick) selects round-robin arbitration.
package pmem_arb_pkg;

    localparam int PMEM_ADDR_W = 32;
    localparam int PMEM_LINE_W = 256;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} pmem_arb_state_t;
    typedef enum logic       {REQ_I, REQ_D}            pmem_arb_req_t;

    function automatic pmem_arb_state_t grant_state(input pmem_arb_req_t r);
        return (r == REQ_D) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/pmem_arb_pick.sv
// Combinational winner selection for the pmem arbiter.
// PMEM_ARB_RR_EN defined: ties go to the requester not granted last; otherwise dcache always wins ties.
module pmem_arb_pick
    import pmem_arb_pkg::*;
(
    input  logic          i_req_i,
    input  logic          d_req_i,
    input  pmem_arb_req_t last_grant_i,
    output logic          valid_o,
    output pmem_arb_req_t winner_o
);

    always_comb begin
        valid_o  = i_req_i | d_req_i;
        winner_o = d_req_i ? REQ_D : REQ_I;
`ifdef PMEM_ARB_RR_EN
        if (i_req_i && d_req_i) begin
            winner_o = (last_grant_i == REQ_D) ? REQ_I : REQ_D;
        end
`endif
    end

`ifndef PMEM_ARB_RR_EN
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant_i == REQ_D);
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one cacheline pmem port between icache (read) and dcache (read/write), one transaction at a time.
// Build option PMEM_ARB_RR_EN enables round-robin; default is fixed dcache-first priority.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int LINE_W = PMEM_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t state_q, state_d;
    pmem_arb_req_t   last_grant, pick_winner;
    logic            d_req, pick_valid;

    assign d_req = d_mem_read | d_mem_write;

    pmem_arb_pick u_pick (
        .i_req_i      (i_mem_read),
        .d_req_i      (d_req),
        .last_grant_i (last_grant),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

`ifdef PMEM_ARB_RR_EN
    pmem_arb_req_t last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (pmem_resp && state_q == GRANT_I) last_grant_d = REQ_I;
        if (pmem_resp && state_q == GRANT_D) last_grant_d = REQ_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= REQ_D;
        else     last_grant_q <= last_grant_d;
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = REQ_D;
`endif

    // Granted side is passed straight through; a dropped request or resp ends the grant.
    always_comb begin
        state_d      = state_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_mem_resp   = 1'b0;
        d_mem_resp   = 1'b0;
        i_mem_rdata  = '0;
        d_mem_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) state_d = grant_state(pick_winner);
            end
            GRANT_I: begin
                pmem_read    = i_mem_read;
                pmem_address = i_mem_address;
                i_mem_resp   = pmem_resp;
                i_mem_rdata  = pmem_rdata;
                d_mem_rdata  = pmem_rdata;
                if (pmem_resp || !i_mem_read) state_d = IDLE;
            end
            GRANT_D: begin
                // Write wins if the dcache ever raises both.
                pmem_write   = d_mem_write;
                pmem_read    = d_mem_read & ~d_mem_write;
                pmem_address = d_mem_address;
                pmem_wdata   = d_mem_wdata;
                d_mem_resp   = pmem_resp;
                i_mem_rdata  = pmem_rdata;
                d_mem_rdata  = pmem_rdata;
                if (pmem_resp || !d_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_mem_read && d_mem_write));
    a_i_hold:    assert property (@(posedge clk) disable iff (rst) (state_q == GRANT_I) |-> i_mem_read);
    a_d_hold:    assert property (@(posedge clk) disable iff (rst) (state_q == GRANT_D) |-> d_req);
    a_resp_idle: assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> !pmem_resp);
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed scenarios plus random icache/dcache traffic.
`timescale 1ns/1ps
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
`ifdef PMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_mem_read = 1'b0;
    logic [AW-1:0] i_mem_address = '0;
    logic [LW-1:0] i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read = 1'b0, d_mem_write = 1'b0;
    logic [AW-1:0] d_mem_address = '0;
    logic [LW-1:0] d_mem_wdata = '0;
    logic [LW-1:0] d_mem_rdata;
    logic          d_mem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct { bit wr; logic [AW-1:0] addr; } sb_t;
    sb_t           i_sb[$], d_sb[$];
    logic [AW-1:0] served[$];
    int            fixed_lat = 0;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Adaptor stub data: 0x60 returns all A5.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'hA5A5_A5A5 ^ (a - 32'h60);
        return {8{w}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Cacheline adaptor stub: responds on the lat-th active cycle.
    initial begin
        int cnt, lat;
        cnt = 0;
        lat = 1;
        forever begin
            @(posedge clk);
            #2;
            pmem_rdata = rand_line();
            if (rst) begin
                cnt = 0;
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (cnt == 0) begin
                    served.push_back(pmem_address);
                    lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
                end
                cnt++;
                pmem_resp = (cnt == lat);
                if (pmem_resp) begin
                    pmem_rdata = line_of(pmem_address);
                    cnt = 0;
                end
            end else begin
                pmem_resp = 1'b0;
                cnt = 0;
            end
        end
    end

    // Reference model: the bus is free or owned; a free cycle with requests hands ownership
    // to the arbitration winner for the following cycle; resp frees it again.
    bit busy_m = 1'b0, own_d = 1'b0, last_d = 1'b1;

    function automatic bit pick_d(input bit ir, input bit dr);
        if (ir && dr) return RR ? !last_d : 1'b1;
        return dr;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy_m = 1'b0;
            last_d = 1'b1;
        end else if (!busy_m) begin
            chk_b("idle_pmem_read", pmem_read, 1'b0);
            chk_b("idle_pmem_write", pmem_write, 1'b0);
            chk_b("idle_i_resp", i_mem_resp, 1'b0);
            chk_b("idle_d_resp", d_mem_resp, 1'b0);
            chk_w("idle_i_rdata", i_mem_rdata, '0);
            if (i_mem_read || d_mem_read || d_mem_write) begin
                own_d  = pick_d(i_mem_read, d_mem_read | d_mem_write);
                busy_m = 1'b1;
            end
        end else begin
            if (own_d) begin
                chk_b("gd_pmem_write", pmem_write, d_mem_write);
                chk_b("gd_pmem_read", pmem_read, d_mem_read & ~d_mem_write);
                chk_a("gd_pmem_address", pmem_address, d_mem_address);
                chk_w("gd_pmem_wdata", pmem_wdata, d_mem_wdata);
            end else begin
                chk_b("gi_pmem_write", pmem_write, 1'b0);
                chk_b("gi_pmem_read", pmem_read, i_mem_read);
                chk_a("gi_pmem_address", pmem_address, i_mem_address);
                chk_w("gi_pmem_wdata", pmem_wdata, '0);
            end
            chk_b("grant_i_resp", i_mem_resp, pmem_resp & ~own_d);
            chk_b("grant_d_resp", d_mem_resp, pmem_resp & own_d);
            if (pmem_resp) begin
                chk_w("bcast_i_rdata", i_mem_rdata, pmem_rdata);
                chk_w("bcast_d_rdata", d_mem_rdata, pmem_rdata);
                last_d = own_d;
                busy_m = 1'b0;
            end
        end
    end

    // Response scoreboard.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && i_mem_resp) begin
            chk_b("i_resp_expected", i_sb.size() != 0, 1'b1);
            if (i_sb.size() != 0) begin
                e = i_sb.pop_front();
                chk_w("i_rdata", i_mem_rdata, line_of(e.addr));
            end
        end
        if (!rst && d_mem_resp) begin
            chk_b("d_resp_expected", d_sb.size() != 0, 1'b1);
            if (d_sb.size() != 0) begin
                e = d_sb.pop_front();
                if (!e.wr) chk_w("d_rdata", d_mem_rdata, line_of(e.addr));
            end
        end
    end

    task automatic wait_resp(input bit is_d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_mem_resp : i_mem_resp) && n < 400);
        chk_b(is_d ? "d_resp_in_time" : "i_resp_in_time", is_d ? d_mem_resp : i_mem_resp, 1'b1);
    endtask

    // Ops start and end at posedge+1, so a following call re-requests in the idle cycle.
    task automatic i_op(input logic [AW-1:0] a);
        i_mem_read    = 1'b1;
        i_mem_address = a;
        i_sb.push_back('{1'b0, a});
        wait_resp(1'b0);
        @(posedge clk);
        #1;
        i_mem_read = 1'b0;
    endtask

    task automatic d_op(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        d_mem_write   = wr;
        d_mem_read    = !wr;
        d_mem_address = a;
        d_mem_wdata   = wd;
        d_sb.push_back('{wr, a});
        wait_resp(1'b1);
        @(posedge clk);
        #1;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_pmem_read", pmem_read, 1'b0);
        chk_b("rst_pmem_write", pmem_write, 1'b0);
        chk_b("rst_i_resp", i_mem_resp, 1'b0);
        chk_b("rst_d_resp", d_mem_resp, 1'b0);
        chk_a("rst_pmem_address", pmem_address, '0);
        chk_w("rst_pmem_wdata", pmem_wdata, '0);
        chk_w("rst_d_rdata", d_mem_rdata, '0);
        rst = 1'b0;
        served.delete();
    endtask

    task automatic chk_served(input string nm, input int idx, input logic [AW-1:0] exp);
        logic [AW-1:0] got;
        got = (served.size() > idx) ? served[idx] : 32'hDEAD_DEAD;
        chk_a(nm, got, exp);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Simultaneous icache/dcache reads.
        fork
            i_op(32'h0000_0040);
            d_op(1'b0, 32'h0000_0080, '0);
        join
        chk_served("tie_first", 0, RR ? 32'h40 : 32'h80);
        chk_served("tie_second", 1, RR ? 32'h80 : 32'h40);

        // Dcache writeback then fill back-to-back, icache waiting one cycle behind.
        served.delete();
        fork
            begin
                d_op(1'b1, 32'h0000_2000, rand_line());
                d_op(1'b0, 32'h0000_3000, '0);
            end
            begin
                @(posedge clk);
                #1;
                i_op(32'h0000_4400);
            end
        join
        chk_served("wb_fill_0", 0, 32'h2000);
        chk_served("wb_fill_1", 1, RR ? 32'h4400 : 32'h3000);
        chk_served("wb_fill_2", 2, RR ? 32'h3000 : 32'h4400);

        // Lone icache fill with a 10-cycle adaptor.
        fixed_lat = 10;
        i_op(32'h0000_0060);
        fixed_lat = 0;

        // Lone dcache writeback.
        d_op(1'b1, 32'h0000_1000, {8{32'h1234_5678}});

        // Long adaptor stall; the model checks address/data every cycle.
        fixed_lat = 50;
        d_op(1'b1, 32'h0000_7020, rand_line());
        fixed_lat = 0;

        // Reset in the middle of a dcache transaction.
        fixed_lat     = 100;
        d_mem_read    = 1'b1;
        d_mem_address = 32'h0000_5000;
        repeat (4) @(posedge clk);
        #1;
        chk_b("pre_rst_granted", pmem_read, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_b("midrst_pmem_read", pmem_read, 1'b0);
        chk_b("midrst_pmem_write", pmem_write, 1'b0);
        chk_b("midrst_d_resp", d_mem_resp, 1'b0);
        chk_a("midrst_pmem_address", pmem_address, '0);
        d_mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        fixed_lat = 0;
        repeat (5) begin
            @(negedge clk);
            chk_b("post_rst_no_resp", d_mem_resp, 1'b0);
        end
        @(posedge clk);
        #1;

        // Random concurrent traffic.
        fork
            begin
                repeat (40) begin
                    gap();
                    i_op({$urandom_range(0, 32'hFFFF), 5'h0} | AW'($urandom_range(0, 31)));
                end
            end
            begin
                repeat (40) begin
                    gap();
                    if ($urandom_range(0, 1) == 1) d_op(1'b1, AW'($urandom), rand_line());
                    else                           d_op(1'b0, AW'($urandom), '0);
                end
            end
        join

        repeat (3) @(posedge clk);
        chk_b("i_sb_drained", i_sb.size() == 0, 1'b1);
        chk_b("d_sb_drained", d_sb.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
